// File: rtl/aes_key_expand_pkg.sv
// aes_key_expand_pkg
// Shared constants for the AES-128 key schedule:
//   - the AES S-box table (also used by the SubBytes stage),
//   - the Rcon seed and the xtime reduction polynomial,
//   - the key-expansion FSM state encoding.
// No ports; import with aes_key_expand_pkg::*.
package aes_key_expand_pkg;

  localparam logic [7:0] RCON_INIT  = 8'h01;
  localparam logic [7:0] XTIME_POLY = 8'h1b;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OUT  = 2'd1,
    CALC = 2'd2
  } state_t;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Multiply by x in GF(2^8): shift left, fold the overflow bit back in.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return a[7] ? ((a << 1) ^ XTIME_POLY) : (a << 1);
  endfunction

endpackage

// File: rtl/aes_key_expand_if.sv
// aes_key_expand_if
// Handshake bundle between a key-schedule requester/consumer and
// aes_key_expand.
//   start, key_in      : request a new expansion with this cipher key
//   round_key/round_idx: current round key and its index
//   key_valid/key_ready: round key handshake
//   busy, done         : status; done pulses after the last key is taken
// Modports: master = requester/consumer side, slave = aes_key_expand.
interface aes_key_expand_if;
  logic         start;
  logic [127:0] key_in;
  logic [127:0] round_key;
  logic [3:0]   round_idx;
  logic         key_valid;
  logic         key_ready;
  logic         busy;
  logic         done;

  modport master (
    output start, key_in, key_ready,
    input  round_key, round_idx, key_valid, busy, done
  );

  modport slave (
    input  start, key_in, key_ready,
    output round_key, round_idx, key_valid, busy, done
  );
endinterface

// File: rtl/aes_key_gword.sv
// aes_key_gword
// Combinational "g" function of the AES key schedule:
//   g_out = SubWord(RotWord(w_in)) ^ {rcon, 24'h0}
// Ports:
//   w_in  [31:0] last word of the previous round key
//   rcon  [7:0]  round constant for this step
//   g_out [31:0] word to fold into w0 of the next round key
module aes_key_gword
  import aes_key_expand_pkg::*;
(
  input  logic [31:0] w_in,
  input  logic [7:0]  rcon,
  output logic [31:0] g_out
);

  logic [31:0] rot_word;
  logic [31:0] sub_word;

  // Byte 0 is the most significant byte; rotating left moves it to the bottom.
  assign rot_word = {w_in[23:0], w_in[31:24]};

  assign sub_word = {SBOX[rot_word[31:24]], SBOX[rot_word[23:16]],
                     SBOX[rot_word[15:8]],  SBOX[rot_word[7:0]]};

  assign g_out = sub_word ^ {rcon, 24'h0};

endmodule

// File: rtl/aes_key_expand.sv
// aes_key_expand
// Iterative AES-128 key schedule. After an accepted start it presents
// round keys 0..NUM_ROUNDS one at a time, each held until the consumer
// takes it, computing the next key in a single CALC cycle in between.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : aes_key_expand_if.slave (start/key_in in, round key handshake
//           and busy/done status out)
// Parameter NUM_ROUNDS: index of the last round key (1..10).
module aes_key_expand
  import aes_key_expand_pkg::*;
#(
  parameter int NUM_ROUNDS = 10
) (
  input logic              clk,
  input logic              rst_n,
  aes_key_expand_if.slave  bus
);

  localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS);

  state_t       state;
  state_t       state_next;
  logic [127:0] round_key_q;
  logic [3:0]   round_idx_q;
  logic [7:0]   rcon_q;
  logic         done_q;

  logic         accept;
  logic         last_key;
  logic [31:0]  g_word;
  logic [31:0]  w0_n, w1_n, w2_n, w3_n;

  assign accept   = (state == OUT) && bus.key_ready;
  assign last_key = (round_idx_q == LAST_IDX);

  aes_key_gword u_gword (
    .w_in  (round_key_q[31:0]),
    .rcon  (rcon_q),
    .g_out (g_word)
  );

  // Each new word chains off the freshly computed word before it.
  assign w0_n = round_key_q[127:96] ^ g_word;
  assign w1_n = round_key_q[95:64]  ^ w0_n;
  assign w2_n = round_key_q[63:32]  ^ w1_n;
  assign w3_n = round_key_q[31:0]   ^ w2_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // start is only looked at in IDLE, so a start during an expansion
  // (including the cycle of the final accept) is simply dropped.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = OUT;
      OUT:     if (bus.key_ready) state_next = last_key ? IDLE : CALC;
      CALC:    state_next = OUT;
      default: state_next = IDLE;
    endcase
  end

  // Round key, index and rcon only change on an accepted start or in CALC,
  // which keeps them frozen for the whole of OUT however long it stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      round_key_q <= '0;
      round_idx_q <= '0;
      rcon_q      <= RCON_INIT;
      done_q      <= 1'b0;
    end else begin
      done_q <= accept && last_key;
      case (state)
        IDLE: begin
          if (bus.start) begin
            round_key_q <= bus.key_in;
            round_idx_q <= '0;
            rcon_q      <= RCON_INIT;
          end
        end
        CALC: begin
          round_key_q <= {w0_n, w1_n, w2_n, w3_n};
          round_idx_q <= round_idx_q + 4'd1;
          rcon_q      <= xtime(rcon_q);
        end
        default: ;
      endcase
    end
  end

  assign bus.round_key = round_key_q;
  assign bus.round_idx = round_idx_q;
  assign bus.key_valid = (state == OUT);
  assign bus.busy      = (state != IDLE);
  assign bus.done      = done_q;

endmodule

// File: tb/tb_aes_key_expand.sv
// tb_aes_key_expand
// Self-checking bench for aes_key_expand. The reference schedule is built
// from the FIPS-197 word recurrence with an S-box derived from GF(2^8)
// inversion plus the affine map, independent of the design's tables.
module tb_aes_key_expand;

  localparam int NUM_ROUNDS = 10;

  logic clk;
  logic rst_n;
  int   cyc;
  int   vectors;
  int   miscompares;

  aes_key_expand_if bus ();

  aes_key_expand #(.NUM_ROUNDS(NUM_ROUNDS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  logic [7:0]   ref_sbox [256];
  logic [127:0] model_rk [0:NUM_ROUNDS];

  // Carry-less polynomial product reduced modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] prod;
    prod = '0;
    for (int i = 0; i < 8; i++)
      if (b[i]) prod = prod ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--)
      if (prod[i]) prod = prod ^ (16'h011b << (i - 8));
    return prod[7:0];
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int k);
    logic [7:0] r;
    r = x;
    for (int i = 0; i < k; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int v = 0; v < 256; v++) begin
      inv = 8'h01;
      for (int e = 0; e < 254; e++) inv = gmul(inv, 8'(v));
      ref_sbox[v] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^
                    rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic model_expand(input logic [127:0] key);
    logic [31:0] w [0:4*NUM_ROUNDS+3];
    logic [31:0] temp;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 4*NUM_ROUNDS+4; i++) begin
      temp = w[i-1];
      if (i % 4 == 0) begin
        temp = {temp[23:0], temp[31:24]};
        temp = {ref_sbox[temp[31:24]], ref_sbox[temp[23:16]],
                ref_sbox[temp[15:8]], ref_sbox[temp[7:0]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ temp;
    end
    for (int r = 0; r <= NUM_ROUNDS; r++)
      model_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // ---------------- sequence collector ----------------
  logic [127:0] got_key [0:NUM_ROUNDS];
  logic [3:0]   got_idx [0:NUM_ROUNDS];
  int           got_cyc [0:NUM_ROUNDS];
  logic [127:0] stall_key [0:15];
  logic [3:0]   stall_idx [0:15];
  logic         stall_valid [0:15];

  // Entered #1 after a rising edge with the DUT idle. Pulses start, then
  // consumes round keys, recording what was accepted and when.
  task automatic collect(input logic [127:0] key, input int stall_round,
                         input int stall_len, input bit spam,
                         input bit rand_ready, output int n, output int start_cyc);
    int budget;
    int stall_cnt;
    n = 0;
    stall_cnt = 0;
    budget = 400;
    bus.key_in = key;
    bus.start = 1'b1;
    bus.key_ready = 1'b0;
    @(posedge clk); #1;
    start_cyc = cyc;
    if (spam) begin
      bus.start = 1'b1;
      bus.key_in = '0;
    end else begin
      bus.start = 1'b0;
      bus.key_in = {$urandom, $urandom, $urandom, $urandom};
    end
    while (n <= NUM_ROUNDS && budget > 0) begin
      if (n == stall_round && bus.key_valid && stall_cnt < stall_len) begin
        stall_key[stall_cnt] = bus.round_key;
        stall_idx[stall_cnt] = bus.round_idx;
        stall_valid[stall_cnt] = bus.key_valid;
        stall_cnt++;
        bus.key_ready = 1'b0;
      end else if (rand_ready) begin
        bus.key_ready = 1'($urandom_range(0, 1));
      end else begin
        bus.key_ready = 1'b1;
      end
      if (bus.key_valid && bus.key_ready) begin
        got_key[n] = bus.round_key;
        got_idx[n] = bus.round_idx;
        got_cyc[n] = cyc;
        n++;
      end
      @(posedge clk); #1;
      budget--;
    end
    bus.start = 1'b0;
    bus.key_ready = 1'b0;
  endtask

  // done must never coincide with key_valid.
  always @(negedge clk) begin
    if (rst_n && bus.done === 1'b1) begin
      vectors++;
      if (bus.key_valid !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL done_excl: key_valid=%b while done=1, required 0", bus.key_valid);
      end
    end
  end

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.key_in = '0;
    bus.key_ready = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if (bus.round_key !== 128'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_round_key: got %h required 0", bus.round_key);
    end
    vectors++;
    if (bus.round_idx !== 4'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_round_idx: got %0d required 0", bus.round_idx);
    end
    vectors++;
    if ({bus.key_valid, bus.busy, bus.done} !== 3'b000) begin
      miscompares++;
      $display("[TB] FAIL reset_flags: valid/busy/done got %b required 000",
               {bus.key_valid, bus.busy, bus.done});
    end
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({bus.key_valid, bus.busy, bus.done} !== 3'b000) begin
      miscompares++;
      $display("[TB] FAIL idle_no_start: valid/busy/done got %b required 000",
               {bus.key_valid, bus.busy, bus.done});
    end
  endtask

  task automatic test_fips_a1();
    logic [127:0] key;
    int n, sc;
    key = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    model_expand(key);
    collect(key, -1, 0, 1'b0, 1'b0, n, sc);
    vectors++;
    if (n !== NUM_ROUNDS + 1) begin
      miscompares++;
      $display("[TB] FAIL a1_count: got %0d keys required %0d", n, NUM_ROUNDS + 1);
    end
    vectors++;
    if (got_key[0] !== key) begin
      miscompares++;
      $display("[TB] FAIL a1_round0: got %h required %h", got_key[0], key);
    end
    vectors++;
    if (got_key[1] !== 128'ha0fafe1788542cb123a339392a6c7605) begin
      miscompares++;
      $display("[TB] FAIL a1_round1: got %h required a0fafe1788542cb123a339392a6c7605", got_key[1]);
    end
    vectors++;
    if (got_key[2] !== 128'hf2c295f27a96b9435935807a7359f67f) begin
      miscompares++;
      $display("[TB] FAIL a1_round2: got %h required f2c295f27a96b9435935807a7359f67f", got_key[2]);
    end
    vectors++;
    if (got_key[10] !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin
      miscompares++;
      $display("[TB] FAIL a1_round10: got %h required d014f9a8c9ee2589e13f0cc8b6630ca6", got_key[10]);
    end
    for (int r = 0; r <= NUM_ROUNDS; r++) begin
      vectors++;
      if (got_key[r] !== model_rk[r] || got_idx[r] !== 4'(r)) begin
        miscompares++;
        $display("[TB] FAIL a1_seq r%0d: got idx %0d key %h required idx %0d key %h",
                 r, got_idx[r], got_key[r], r, model_rk[r]);
      end
      vectors++;
      if (got_cyc[r] - sc !== 2 * r) begin
        miscompares++;
        $display("[TB] FAIL a1_latency r%0d: got %0d cycles required %0d", r, got_cyc[r] - sc, 2 * r);
      end
    end
    vectors++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL a1_done_pulse: done/busy got %b%b required 10", bus.done, bus.busy);
    end
    @(posedge clk); #1;
    vectors++;
    if (bus.done !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL a1_done_width: done got %b required 0", bus.done);
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] key;
    int n, sc, extra;
    key = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    model_expand(key);
    collect(key, 3, 7, 1'b0, 1'b0, n, sc);
    for (int i = 0; i < 7; i++) begin
      vectors++;
      if (stall_key[i] !== model_rk[3] || stall_idx[i] !== 4'd3 || stall_valid[i] !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL stall_hold c%0d: got valid %b idx %0d key %h required 1 3 %h",
                 i, stall_valid[i], stall_idx[i], stall_key[i], model_rk[3]);
      end
    end
    vectors++;
    if (n !== NUM_ROUNDS + 1) begin
      miscompares++;
      $display("[TB] FAIL stall_count: got %0d keys required %0d", n, NUM_ROUNDS + 1);
    end
    for (int r = 0; r <= NUM_ROUNDS; r++) begin
      extra = (r >= 3) ? 7 : 0;
      vectors++;
      if (got_key[r] !== model_rk[r] || got_idx[r] !== 4'(r) || got_cyc[r] - sc !== 2 * r + extra) begin
        miscompares++;
        $display("[TB] FAIL stall_seq r%0d: got idx %0d t%0d key %h required idx %0d t%0d key %h",
                 r, got_idx[r], got_cyc[r] - sc, got_key[r], r, 2 * r + extra, model_rk[r]);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_ignored_start();
    logic [127:0] key;
    int n, sc;
    key = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    model_expand(key);
    collect(key, -1, 0, 1'b1, 1'b0, n, sc);
    vectors++;
    if (n !== NUM_ROUNDS + 1) begin
      miscompares++;
      $display("[TB] FAIL spam_count: got %0d keys required %0d", n, NUM_ROUNDS + 1);
    end
    for (int r = 0; r <= NUM_ROUNDS; r++) begin
      vectors++;
      if (got_key[r] !== model_rk[r] || got_idx[r] !== 4'(r)) begin
        miscompares++;
        $display("[TB] FAIL spam_seq r%0d: got idx %0d key %h required idx %0d key %h",
                 r, got_idx[r], got_key[r], r, model_rk[r]);
      end
    end
    vectors++;
    if (bus.busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL spam_final_start: busy got %b required 0", bus.busy);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    logic [127:0] key;
    int n, sc;
    bus.key_in = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    bus.start = 1'b1;
    bus.key_ready = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    vectors++;
    if (bus.key_valid !== 1'b0 || bus.round_idx !== 4'd5 || bus.busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL midrst_pre: valid/busy got %b%b idx %0d required 01 idx 5",
               bus.key_valid, bus.busy, bus.round_idx);
    end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (bus.round_key !== 128'h0 || bus.round_idx !== 4'd0 ||
        {bus.key_valid, bus.busy, bus.done} !== 3'b000) begin
      miscompares++;
      $display("[TB] FAIL midrst_clear: got key %h idx %0d flags %b required 0 0 000",
               bus.round_key, bus.round_idx, {bus.key_valid, bus.busy, bus.done});
    end
    bus.key_ready = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    key = 128'h000102030405060708090a0b0c0d0e0f;
    model_expand(key);
    collect(key, -1, 0, 1'b0, 1'b0, n, sc);
    vectors++;
    if (got_key[10] !== 128'h13111d7fe3944a17f307a78b4d2b30c5) begin
      miscompares++;
      $display("[TB] FAIL midrst_round10: got %h required 13111d7fe3944a17f307a78b4d2b30c5", got_key[10]);
    end
    for (int r = 0; r <= NUM_ROUNDS; r++) begin
      vectors++;
      if (r >= n || got_key[r] !== model_rk[r] || got_idx[r] !== 4'(r)) begin
        miscompares++;
        $display("[TB] FAIL midrst_seq r%0d: got idx %0d key %h required idx %0d key %h",
                 r, got_idx[r], got_key[r], r, model_rk[r]);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [127:0] k1, k2;
    int n, sc;
    k1 = {$urandom, $urandom, $urandom, $urandom};
    k2 = {$urandom, $urandom, $urandom, $urandom};
    collect(k1, -1, 0, 1'b0, 1'b0, n, sc);
    vectors++;
    if (bus.done !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL b2b_done: done got %b required 1", bus.done);
    end
    model_expand(k2);
    collect(k2, -1, 0, 1'b0, 1'b0, n, sc);
    vectors++;
    if (got_cyc[0] !== sc || got_key[0] !== k2) begin
      miscompares++;
      $display("[TB] FAIL b2b_round0: got t%0d key %h required t%0d key %h",
               got_cyc[0], got_key[0], sc, k2);
    end
    vectors++;
    if (n !== NUM_ROUNDS + 1 || got_key[NUM_ROUNDS] !== model_rk[NUM_ROUNDS]) begin
      miscompares++;
      $display("[TB] FAIL b2b_last: got %0d keys last %h required %0d last %h",
               n, got_key[NUM_ROUNDS], NUM_ROUNDS + 1, model_rk[NUM_ROUNDS]);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [127:0] key;
    int n, sc;
    for (int k = 0; k < 4; k++) begin
      key = {$urandom, $urandom, $urandom, $urandom};
      model_expand(key);
      collect(key, -1, 0, 1'b0, 1'b1, n, sc);
      vectors++;
      if (n !== NUM_ROUNDS + 1) begin
        miscompares++;
        $display("[TB] FAIL rand_count k%0d: got %0d keys required %0d", k, n, NUM_ROUNDS + 1);
      end
      for (int r = 0; r <= NUM_ROUNDS; r++) begin
        vectors++;
        if (got_key[r] !== model_rk[r] || got_idx[r] !== 4'(r)) begin
          miscompares++;
          $display("[TB] FAIL rand_seq k%0d r%0d: got idx %0d key %h required idx %0d key %h",
                   k, r, got_idx[r], got_key[r], r, model_rk[r]);
        end
      end
      repeat ($urandom_range(1, 3)) @(posedge clk);
      #1;
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.key_in = '0;
    bus.key_ready = 1'b0;
    build_sbox();
    $display("[TB] starting aes_key_expand bench");
    test_reset();
    test_fips_a1();
    test_backpressure();
    test_ignored_start();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
